// File: rtl/wb_serial_divider_v2.sv
// Wishbone-mapped restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero result, abort, overrun status and a completion interrupt.
module wb_serial_divider_v2 #(
   parameter int         WBW  = 32,
   parameter int         XLEN = 32,
   parameter logic [3:0] BASE = 4'h3
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [WBW/8-1:0] wbs_sel_i,
   input  logic [WBW-1:0]   wbs_adr_i,
   input  logic [WBW-1:0]   wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [WBW-1:0]   wbs_dat_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             irq_o
);

   localparam int             CW  = $clog2(XLEN);
   localparam logic [WBW-1:0] BAD = WBW'(32'h0BAD_0BAD);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP} state_t;

   state_t            r_state;
   logic              r_ack, r_start, r_done;
   logic [WBW-1:0]    r_rdata;
   logic [XLEN-1:0]   r_dividend, r_divisor, r_quotient, r_remainder;
   logic              r_signed, r_ien, r_fini, r_div0, r_overrun;
   logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_dvs;
   logic              r_sgn;
   logic [CW-1:0]     r_cnt;

   logic              w_req, w_hit, w_wr, w_rd, w_ctrl_wr, w_stat_rd;
   logic              w_busy, w_abort, w_start;
   logic [3:0]        w_off;
   logic [XLEN-1:0]   w_mask, w_a_mag, w_b_mag;
   logic              w_a_neg, w_b_neg, w_q_neg;
   logic [XLEN:0]     w_shift, w_diff;
   logic [WBW-1:0]    w_rdata;
   logic              w_unused;

   assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
   assign w_hit     = (wbs_adr_i[WBW-1 -: 4] == BASE);
   assign w_off     = wbs_adr_i[5:2];
   assign w_wr      = w_req & wbs_we_i & w_hit;
   assign w_rd      = w_req & ~wbs_we_i;
   assign w_ctrl_wr = w_wr & (w_off == 4'd4);
   assign w_stat_rd = w_rd & w_hit & (w_off == 4'd5);
   assign w_busy    = (r_state != S_IDLE);
   assign w_abort   = w_ctrl_wr & wbs_dat_i[2];
   assign w_start   = w_ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[2];
   assign w_unused  = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < XLEN; i++) w_mask[i] = wbs_sel_i[i/8];
   end

   // Operands are magnitudes in signed mode; signs are restored in FIXUP.
   assign w_a_neg = r_sgn & r_a[XLEN-1];
   assign w_b_neg = r_sgn & r_b[XLEN-1];
   assign w_q_neg = w_a_neg ^ w_b_neg;
   assign w_a_mag = w_a_neg ? -r_a : r_a;
   assign w_b_mag = w_b_neg ? -r_b : r_b;
   assign w_shift = {r_rem, r_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};

   always_comb begin
      w_rdata = BAD;
      if (w_hit) begin
         case (w_off)
            4'd0:    w_rdata = WBW'(r_dividend);
            4'd1:    w_rdata = WBW'(r_divisor);
            4'd2:    w_rdata = WBW'(r_quotient);
            4'd3:    w_rdata = WBW'(r_remainder);
            4'd4:    w_rdata = WBW'({r_ien, 1'b0, r_signed, 1'b0});
            4'd5:    w_rdata = WBW'({r_overrun, r_div0, r_fini, w_busy});
            default: w_rdata = BAD;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; later assignments in the
   // same block deliberately override earlier ones (e.g. FIXUP setting fini over a read-clear).
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= w_req;
         if (w_rd) r_rdata <= w_rdata;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_signed    <= 1'b0;
         r_ien       <= 1'b0;
         r_fini      <= 1'b0;
         r_div0      <= 1'b0;
         r_overrun   <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sgn       <= 1'b0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_dvs       <= '0;
         r_cnt       <= '0;
      end else begin
         r_done  <= 1'b0;
         r_start <= w_start & ~w_busy;
         if (w_wr && w_off == 4'd0)
            r_dividend <= (r_dividend & ~w_mask) | (wbs_dat_i[XLEN-1:0] & w_mask);
         if (w_wr && w_off == 4'd1)
            r_divisor <= (r_divisor & ~w_mask) | (wbs_dat_i[XLEN-1:0] & w_mask);
         if (w_ctrl_wr) begin
            r_signed <= wbs_dat_i[1];
            r_ien    <= wbs_dat_i[3];
         end
         if (w_stat_rd) begin
            r_fini    <= 1'b0;
            r_overrun <= 1'b0;
         end
         if (w_start && w_busy) r_overrun <= 1'b1;

         if (w_abort && w_busy) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: if (r_start) begin
                  r_state <= S_PREP;
                  r_a     <= r_dividend;
                  r_b     <= r_divisor;
                  r_sgn   <= r_signed;
                  r_fini  <= 1'b0;
                  r_div0  <= 1'b0;
               end
               S_PREP: begin
                  r_quo   <= w_a_mag;
                  r_dvs   <= w_b_mag;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_state <= (r_b == '0) ? S_FIXUP : S_CALC;
               end
               S_CALC: begin
                  r_rem   <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
                  r_quo   <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
                  r_cnt   <= r_cnt + CW'(1);
                  if (r_cnt == CW'(XLEN-1)) r_state <= S_FIXUP;
               end
               S_FIXUP: begin
                  if (r_b == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= r_a;
                     r_div0      <= 1'b1;
                  end else begin
                     r_quotient  <= w_q_neg ? -r_quo : r_quo;
                     r_remainder <= w_a_neg ? -r_rem : r_rem;
                  end
                  r_fini  <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_rdata;
   assign busy_o    = w_busy;
   assign done_o    = r_done;
   assign irq_o     = r_fini & r_ien;

endmodule

// File: tb/tb_wb_serial_divider_v2.sv
// Directed bench for wb_serial_divider_v2: table of divisions plus hand-written
// sequences for overrun, abort, interrupt, byte lanes, decode errors and async reset.
module tb_wb_serial_divider_v2;

   localparam logic [31:0] A_BASE = 32'h3000_0000;
   localparam logic [31:0] BAD    = 32'h0BAD_0BAD;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        busy_o, done_o, irq_o;

   int n_vec = 0;
   int n_err = 0;

   wb_serial_divider_v2 #(.WBW(32), .XLEN(32), .BASE(4'h3)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic        sgn;
      logic [31:0] q;
      logic [31:0] r;
      logic [31:0] st;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
      @(negedge clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #1;
         if (wbs_ack_o) break;
      end
      if (!wbs_ack_o) begin
         n_vec++; n_err++;
         $display("FAIL wb_ack timeout: adr 0x%08h", adr);
      end
      rd = wbs_dat_o;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wb_write(input logic [3:0] off, input logic [31:0] dat);
      logic [31:0] dummy;
      wb_cycle(1'b1, A_BASE + {26'd0, off, 2'b00}, dat, 4'hF, dummy);
   endtask

   task automatic wb_read(input logic [3:0] off, output logic [31:0] rd);
      wb_cycle(1'b0, A_BASE + {26'd0, off, 2'b00}, 32'h0, 4'hF, rd);
   endtask

   task automatic rd_check(input string name, input logic [3:0] off, input logic [31:0] exp);
      logic [31:0] rd;
      wb_read(off, rd);
      check(name, rd, exp);
   endtask

   // Counts clocks from the end of the START write until done_o; k = -1 on timeout.
   task automatic wait_done(output int k, output logic b1);
      k  = -1;
      b1 = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk_i); #1;
         if (i == 1) b1 = busy_o;
         if (done_o) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      logic        b1;
      logic [31:0] rd;
      int          n_done;

      vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         32'h2};
      vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  32'h2};
      vecs[2] = '{32'hFFFFFFF9,  32'd2,         1'b0, 32'h7FFFFFFC,  32'd1,         32'h2};
      vecs[3] = '{32'h1234,      32'd0,         1'b0, 32'hFFFFFFFF,  32'h1234,      32'h6};
      vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         32'h2};
      vecs[5] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         32'h2};
      vecs[6] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        32'hFFFFFFFE,  32'h2};
      vecs[7] = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         32'h2};
      vecs[8] = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         32'h2};
      vecs[9] = '{32'hFFFFFFFB,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB,  32'h6};

      reset_i = 1'b1;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      for (int i = 0; i < 6; i++) rd_check($sformatf("rst_csr%0d", i), 4'(i), 32'd0);

      for (int v = 0; v < 10; v++) begin
         wb_write(4'd0, vecs[v].dvd);
         wb_write(4'd1, vecs[v].dvs);
         wb_write(4'd4, vecs[v].sgn ? 32'h3 : 32'h1);
         wait_done(k, b1);
         check($sformatf("v%0d_busy", v), {31'd0, b1}, 32'd1);
         check($sformatf("v%0d_latency", v), k, (vecs[v].dvs == 0) ? 32'd3 : 32'd35);
         @(posedge clk_i); #1;
         check($sformatf("v%0d_done_pulse", v), {31'd0, done_o}, 32'd0);
         rd_check($sformatf("v%0d_q", v), 4'd2, vecs[v].q);
         rd_check($sformatf("v%0d_r", v), 4'd3, vecs[v].r);
         rd_check($sformatf("v%0d_status", v), 4'd5, vecs[v].st);
         rd_check($sformatf("v%0d_status2", v), 4'd5, vecs[v].st & ~32'h2);
      end

      // START while busy: overrun flagged, running op uses its latched operands
      wb_write(4'd0, 32'd100);
      wb_write(4'd1, 32'd7);
      wb_write(4'd4, 32'h1);
      repeat (3) @(posedge clk_i);
      wb_write(4'd0, 32'd999);
      wb_write(4'd4, 32'h1);
      wait_done(k, b1);
      check("ovr_done_seen", {31'd0, (k > 0)}, 32'd1);
      rd_check("ovr_q", 4'd2, 32'd14);
      rd_check("ovr_r", 4'd3, 32'd2);
      rd_check("ovr_status", 4'd5, 32'hA);
      rd_check("ovr_status2", 4'd5, 32'h0);

      // ABORT mid-calculation
      wb_write(4'd0, 32'd1000);
      wb_write(4'd1, 32'd3);
      wb_write(4'd4, 32'h1);
      repeat (8) @(posedge clk_i);
      #1;
      check("abort_busy_before", {31'd0, busy_o}, 32'd1);
      wb_write(4'd4, 32'h4);
      check("abort_busy_after", {31'd0, busy_o}, 32'd0);
      n_done = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk_i); #1;
         if (done_o) n_done++;
      end
      check("abort_no_done", n_done, 32'd0);
      rd_check("abort_q", 4'd2, 32'd14);
      rd_check("abort_r", 4'd3, 32'd2);
      rd_check("abort_status", 4'd5, 32'h0);

      // START+ABORT together while idle: nothing starts
      wb_write(4'd4, 32'h5);
      @(posedge clk_i); @(posedge clk_i); #1;
      check("sa_busy", {31'd0, busy_o}, 32'd0);
      rd_check("sa_status", 4'd5, 32'h0);

      // Interrupt: held until STATUS read
      wb_write(4'd0, 32'h80000000);
      wb_write(4'd1, 32'hFFFFFFFF);
      wb_write(4'd4, 32'hB);
      wait_done(k, b1);
      check("irq_latency", k, 32'd35);
      check("irq_set", {31'd0, irq_o}, 32'd1);
      repeat (5) @(posedge clk_i);
      #1;
      check("irq_hold", {31'd0, irq_o}, 32'd1);
      rd_check("irq_ctrl", 4'd4, 32'hA);
      rd_check("irq_q", 4'd2, 32'h80000000);
      rd_check("irq_r", 4'd3, 32'd0);
      check("irq_after_q_read", {31'd0, irq_o}, 32'd1);
      rd_check("irq_status", 4'd5, 32'h2);
      check("irq_cleared_by_read", {31'd0, irq_o}, 32'd0);

      // Interrupt cleared by dropping IEN; fini stays set
      wb_write(4'd4, 32'h9);
      wait_done(k, b1);
      check("ien_irq_set", {31'd0, irq_o}, 32'd1);
      wb_write(4'd4, 32'h0);
      check("ien_irq_clear", {31'd0, irq_o}, 32'd0);
      rd_check("ien_status", 4'd5, 32'h2);
      rd_check("ien_q", 4'd2, 32'd0);
      rd_check("ien_r", 4'd3, 32'h80000000);

      // Byte lanes, decode errors, read-only registers
      wb_write(4'd0, 32'h0);
      wb_cycle(1'b1, A_BASE, 32'hAABBCCDD, 4'b0010, rd);
      rd_check("lane_dividend", 4'd0, 32'h0000CC00);
      rd_check("bad_off6", 4'd6, BAD);
      rd_check("bad_off15", 4'd15, BAD);
      wb_cycle(1'b0, 32'h4000_0000, 32'h0, 4'hF, rd);
      check("bad_base_read", rd, BAD);
      wb_cycle(1'b1, 32'h4000_0000, 32'h55, 4'hF, rd);
      rd_check("bad_base_write_dropped", 4'd0, 32'h0000CC00);
      wb_write(4'd2, 32'h1234);
      rd_check("ro_quotient", 4'd2, 32'd0);
      wb_write(4'd5, 32'hF);
      rd_check("ro_status", 4'd5, 32'h0);

      // Asynchronous reset in the middle of CALC
      wb_write(4'd0, 32'd100);
      wb_write(4'd1, 32'd7);
      wb_write(4'd4, 32'hB);
      rd_check("prerst_ctrl", 4'd4, 32'hA);
      repeat (10) @(posedge clk_i);
      #3 reset_i = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      check("arst_done", {31'd0, done_o}, 32'd0);
      check("arst_irq", {31'd0, irq_o}, 32'd0);
      check("arst_dat", wbs_dat_o, 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      for (int i = 0; i < 6; i++) rd_check($sformatf("arst_csr%0d", i), 4'(i), 32'd0);

      // Recovery after reset
      wb_write(4'd0, 32'd100);
      wb_write(4'd1, 32'd7);
      wb_write(4'd4, 32'h1);
      wait_done(k, b1);
      check("post_rst_latency", k, 32'd35);
      rd_check("post_rst_q", 4'd2, 32'd14);
      rd_check("post_rst_r", 4'd3, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
